// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: captures a load/store on req, waits a fixed
// number of cycles, then answers with a one-cycle ack carrying rdata and err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_live;
  logic          w_op_we;
  logic [31:0]   w_op_addr;
  logic [31:0]   w_op_wdata;
  logic [AW-1:0] w_idx;
  logic          w_bad;
  logic          w_enter_resp;
  logic          w_wr_en;

  // With zero wait states the access completes on the accepting edge, so the
  // operation must come straight from the inputs rather than the capture regs.
  assign w_live     = (r_state == S_IDLE);
  assign w_op_we    = w_live ? we    : r_we;
  assign w_op_addr  = w_live ? addr  : r_addr;
  assign w_op_wdata = w_live ? wdata : r_wdata;

  assign w_idx = w_op_addr[AW+1:2];
  assign w_bad = (w_op_addr[1:0] != 2'b00) || (w_op_addr[31:AW+2] != '0);

  assign w_enter_resp = ((r_state == S_IDLE) && req && (WAIT_STATES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_wr_en      = reset && w_enter_resp && w_op_we && !w_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // rdata is only touched on completion so it holds between responses
      if (w_enter_resp) begin
        r_err   <= w_bad;
        r_rdata <= w_bad ? '0 : (w_op_we ? w_op_wdata : r_mem[w_idx]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= w_op_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ack   = (r_state == S_RESP);
  assign err   = (r_state == S_RESP) && r_err;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table through a scoreboard on the 2-wait-state
// build, plus hand sequences for timing, ignored requests, reset and 0-wait build.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, err, busy;

  logic        z_reset, z_req, z_we;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic        z_ack, z_err, z_busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(z_reset), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata),
    .rdata(z_rdata), .ack(z_ack), .err(z_err), .busy(z_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack of the main build pops one expected response.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_ack: got ack with rdata %h, expected no ack", rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_err", 32'(err), 32'(e.err));
        $display("[TB] resp rdata=%h err=%0b", rdata, err);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_ack();
    int k;
    k = 0;
    @(negedge clk);
    while (ack !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) chk("ack_timeout", 32'(ack), 32'd1);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    wait_idle();
    e.rdata = er;
    e.err   = ee;
    sb_q.push_back(e);
    we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    wait_ack();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0,         1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h1111_2222, 32'h1111_2222, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_2222, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 32'h0000_0004, 32'h3333_4444, 32'h3333_4444, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0104, 32'h5555_6666, 32'h0,         1'b1};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         32'h3333_4444, 1'b0};
    vecs[13] = '{1'b1, 32'hFFFF_FFFC, 32'h9999_9999, 32'h0,         1'b1};

    reset = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h0BAD_0BAD;
    z_reset = 1'b0; z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0;

    // Reset held with req high: nothing may be accepted or asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      $display("[TB] reset cycle %0d ack=%0b busy=%0b rdata=%h", i, ack, busy, rdata);
    end
    req = 1'b0; reset = 1'b1; z_reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 14; i++) begin
      $display("[TB] vec %0d we=%0b addr=%h wdata=%h", i, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Latency, ignored request while busy, re-acceptance with req held high
    wait_idle();
    begin
      exp_t e;
      e.rdata = 32'hDEAD_BEEF; e.err = 1'b0;
      sb_q.push_back(e);
    end
    we = 1'b0; addr = 32'h10; req = 1'b1;
    @(negedge clk);
    addr = 32'h20;
    chk("lat_busy_c1", 32'(busy), 32'd1);
    chk("lat_ack_c1", 32'(ack), 32'd0);
    @(negedge clk);
    chk("lat_busy_c2", 32'(busy), 32'd1);
    chk("lat_ack_c2", 32'(ack), 32'd0);
    @(negedge clk);
    chk("lat_busy_c3", 32'(busy), 32'd1);
    chk("lat_ack_c3", 32'(ack), 32'd1);
    @(negedge clk);
    chk("lat_busy_c4", 32'(busy), 32'd0);
    chk("lat_ack_c4", 32'(ack), 32'd0);
    chk("lat_rdata_held", rdata, 32'hDEAD_BEEF);
    begin
      exp_t e;
      e.rdata = 32'h1111_2222; e.err = 1'b0;
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("reaccept_busy", 32'(busy), 32'd1);
    req = 1'b0;
    wait_ack();
    $display("[TB] held-req sequence done");

    // Reset during WAIT must abort the store
    wait_idle();
    we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_ack", 32'(ack), 32'd0);
    end
    issue(1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0);
    $display("[TB] mid-write reset sequence done");

    // Zero-wait-state build: ack on the cycle right after acceptance
    @(negedge clk);
    z_we = 1'b1; z_addr = 32'h8; z_wdata = 32'h7777_8888; z_req = 1'b1;
    @(negedge clk);
    z_req = 1'b0;
    chk("ws0_st_ack", 32'(z_ack), 32'd1);
    chk("ws0_st_busy", 32'(z_busy), 32'd1);
    chk("ws0_st_rdata", z_rdata, 32'h7777_8888);
    chk("ws0_st_err", 32'(z_err), 32'd0);
    @(negedge clk);
    chk("ws0_ack_drop", 32'(z_ack), 32'd0);
    chk("ws0_busy_drop", 32'(z_busy), 32'd0);
    z_we = 1'b0; z_wdata = 32'h0; z_req = 1'b1;
    @(negedge clk);
    z_req = 1'b0;
    chk("ws0_ld_ack", 32'(z_ack), 32'd1);
    chk("ws0_ld_rdata", z_rdata, 32'h7777_8888);
    @(negedge clk);
    z_addr = 32'h9; z_req = 1'b1;
    @(negedge clk);
    z_req = 1'b0;
    chk("ws0_bad_ack", 32'(z_ack), 32'd1);
    chk("ws0_bad_err", 32'(z_err), 32'd1);
    chk("ws0_bad_rdata", z_rdata, 32'd0);
    $display("[TB] zero-wait build sequence done");

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
